// File: rtl/led_pattern_sched.sv
// Step sequencer for the 8-LED bank: programmable step prescaler plus four display modes
// (left fill, right fill, ping-pong, blink) with pause and mode-advance control.
module led_pattern_sched #(
    parameter int STEP_DIV = 25000000,
    parameter int DIV_W    = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_req,
    input  logic       pause,
    input  logic [1:0] speed,
    output logic [7:0] led,
    output logic       step,
    output logic [1:0] mode
);

    localparam logic [1:0] WATER_L  = 2'd0;
    localparam logic [1:0] WATER_R  = 2'd1;
    localparam logic [1:0] PINGPONG = 2'd2;
    localparam logic [1:0] BLINK    = 2'd3;

    localparam logic [DIV_W-1:0] DIV_BASE = DIV_W'(STEP_DIV);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    logic [DIV_W-1:0] count;
    logic [DIV_W-1:0] period;
    logic [DIV_W-1:0] term;
    logic             tick;
    logic             dir_right;
    logic             one_hot;
    logic [7:0]       next_led;
    logic             next_dir_right;
    logic [1:0]       next_mode;
    logic [7:0]       init_led;

    // ">=" rather than "==" so a speed increase mid-count ticks immediately instead of wrapping.
    always_comb begin
        period = DIV_BASE >> speed;
        term   = period - DIV_ONE;
        tick   = !pause && (count >= term);
    end

    always_comb begin
        one_hot = (led != 8'h00) && ((led & (led - 8'h01)) == 8'h00);
    end

    always_comb begin
        next_led       = led;
        next_dir_right = dir_right;
        case (mode)
            WATER_L: begin
                next_led = (led == 8'h00) ? 8'hFF : (led << 1);
            end
            WATER_R: begin
                next_led = (led == 8'h00) ? 8'hFF : (led >> 1);
            end
            PINGPONG: begin
                // Direction flips on the step that lands on an end bit; a stray end bit turns around.
                if (!one_hot) begin
                    next_led       = 8'h01;
                    next_dir_right = 1'b0;
                end else if (!dir_right) begin
                    if (led == 8'h80) begin
                        next_led       = 8'h40;
                        next_dir_right = 1'b1;
                    end else begin
                        next_led       = led << 1;
                        next_dir_right = (led == 8'h40);
                    end
                end else begin
                    if (led == 8'h01) begin
                        next_led       = 8'h02;
                        next_dir_right = 1'b0;
                    end else begin
                        next_led       = led >> 1;
                        next_dir_right = (led != 8'h02);
                    end
                end
            end
            BLINK: begin
                next_led = ~led;
            end
            default: begin
                next_led = 8'hFF;
            end
        endcase
    end

    always_comb begin
        next_mode = mode + 2'd1;
        init_led  = (next_mode == PINGPONG) ? 8'h01 : 8'hFF;
    end

    // mode_req outranks a coincident tick; pause only freezes the count, never a mode change.
    always_ff @(posedge clk) begin
        if (rst) begin
            led       <= 8'hFF;
            mode      <= WATER_L;
            step      <= 1'b0;
            count     <= '0;
            dir_right <= 1'b0;
        end else if (mode_req) begin
            mode      <= next_mode;
            led       <= init_led;
            dir_right <= 1'b0;
            count     <= '0;
            step      <= 1'b1;
        end else if (tick) begin
            led       <= next_led;
            dir_right <= next_dir_right;
            count     <= '0;
            step      <= 1'b1;
        end else begin
            step <= 1'b0;
            if (!pause) begin
                count <= count + DIV_ONE;
            end
        end
    end

endmodule

// File: doc/led_pattern_sched.md
# led_pattern_sched

Step-sequencing controller for the 8-LED bank on the CPLD board. It produces the LED step timing with a programmable prescaler and selects among four display modes: left water fill, right water fill, ping-pong, and blink. It also handles pause and mode-advance requests from the board's debounced key logic. It sits between the key conditioning and the LED output pins; active-low pin inversion happens at the top level.

## Interface
- `STEP_DIV`, 25000000: clock cycles per LED step at speed 0; must be ≥ 8.
- `DIV_W`, 25: prescaler counter width; must hold `STEP_DIV`-1.
- `clk` in 1: system clock, 50 MHz on the board.
- `rst` in 1: synchronous, active-high reset.
- `mode_req` in 1: one-cycle pulse; advances to the next mode.
- `pause` in 1: level; high freezes stepping.
- `speed` in 2: step period is `STEP_DIV >> speed`.
- `led` out 8: LED pattern, 1 = lit.
- `step` out 1: one-cycle pulse on every `led` update.
- `mode` out 2: current mode (0 = WATER_L, 1 = WATER_R, 2 = PINGPONG, 3 = BLINK).

## Operation
- **Reset values** (sampled at a `clk` edge with `rst`=1):
  - `led`=8'hFF, `mode`=0, `step`=0.
  - Prescaler count=0, ping-pong direction=left.
  - `rst` overrides all other inputs.
- **Prescaler:**
  - P = `STEP_DIV >> speed`.
  - The count increments each cycle while `pause`=0.
  - When count ≥ P-1, a step tick occurs and the count returns to 0.
  - The ≥ comparison means a speed increase mid-count ticks on the next edge and never waits for a wrap.
  - While `pause`=1 the count holds and no tick occurs.
- **Step action per mode** (the mode is the FSM state):
  - WATER_L: `led <= led << 1`; 8'h00 reloads 8'hFF. Cycle is FF, FE, FC, F8, F0, E0, C0, 80, 00, FF (period 9).
  - WATER_R: `led <= led >> 1`; 8'h00 reloads 8'hFF. Cycle is FF, 7F, 3F, …, 01, 00, FF.
  - PINGPONG: one lit bit moving one position per step.
    - Direction flips on the step that reaches 8'h80 or 8'h01.
    - Sequence is 01, 02, …, 80, 40, …, 02, 01, 02, … (period 14).
    - If `led` is not one-hot, it loads 8'h01 with direction left.
  - BLINK: `led <= ~led`. Starts at 8'hFF.
- **Mode advance:**
  - On `mode_req`=1, the mode goes to (mode+1) mod 4; BLINK wraps to WATER_L.
  - Initial patterns: WATER_L FF, WATER_R FF, PINGPONG 01 with direction left, BLINK FF.
  - The prescaler count clears to 0 and `step` pulses.
  - Applies even while `pause`=1; stepping stays frozen afterwards.
- **Simultaneous events:**
  - `mode_req` and a tick on the same edge: `mode_req` wins and the tick is discarded.
  - `pause` rising on a tick edge: the tick is suppressed (pause is evaluated first).
- `speed` and `pause` are used directly, unsynchronised. Both inputs come from the `clk` domain.

## Timing
- Everything updates on the `clk` rising edge. All outputs are registered and there are no combinational paths from input to output.
- `led`, `mode` and `step` change on the same edge, so `step`=1 in exactly the first cycle a new `led` value is visible.
- Step latency:
  - After reset deasserts, the first `led` change happens at the P-th edge.
  - Steps then repeat every P edges with no pause.
  - Each paused cycle delays the next step by exactly one cycle.
- `mode_req` latency: one edge. `led`/`mode` are updated in the cycle after the pulse.
- Reset mid-operation: outputs return to their reset values on the next edge, whatever the mode, count or `pause`.

## Test plan
All cases use `STEP_DIV`=8.
- **Reset, speed 0:** reset then release with `speed`=0, `pause`=0 → `led`=FF, then FE at edge 8 with `step`=1. Continues FC, F8, …, 80, 00, FF with `step` every 8 cycles.
- **Speed 3:** `speed`=3 (P=1) → `led` steps every cycle and `step` is held high. Changing `speed` 0→2 at count 5 gives a tick on the next edge.
- **Mode advance:** pulse `mode_req` at count 4 → next cycle `mode`=1, `led`=FF, `step`=1. Then 7F appears 8 cycles later, followed by 3F. A further two pulses give `mode`=3, `led`=FF, then 00 and FF alternating.
- **Ping-pong:** in PINGPONG, observe 16 steps → 01, 02, 04, …, 80, 40, 20, …, 02, 01, 02, 04 exactly.
- **Pause and collision:** raise `pause` at count 3 for 10 cycles → `led` frozen and no `step`; the next step comes 5 cycles after release. `mode_req` coincident with a tick edge → only the mode load happens, the count restarts at 0, and there is no extra shift.
- **Reset mid-run:** assert `rst` in PINGPONG at `led`=20 going right with `pause`=1 → `led`=FF, `mode`=0, `step`=0 next cycle. After release, the first step comes 8 cycles later.
